// File: rtl/uart_handshake_retry.sv
// Link bring-up handshake: sends SYNC_BYTE, waits for ACK_BYTE with a timeout, and retries a bounded number of times.
// Includes the 8N1 uart_tx/uart_rx pair it drives; both are held idle while their enable is low.

module uart_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       start,
    input  logic [7:0] data,
    output logic       serial,
    output logic       done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          load;
    logic          shift;

    assign load  = enable && (state == S_IDLE) && start;
    assign shift = enable && (state == S_DATA) && (clk_cnt == BIT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            serial  <= 1'b1;
            done    <= 1'b0;
        end else if (!enable) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            serial  <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    serial <= 1'b1;
                    if (start) begin
                        serial  <= 1'b0;
                        clk_cnt <= '0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        serial  <= shreg[0];
                        state   <= S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            serial <= 1'b1;
                            state  <= S_STOP;
                        end else begin
                            // shreg shifts on this same edge, so the next bit is shreg[1]
                            bit_idx <= bit_idx + 3'd1;
                            serial  <= shreg[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (load) begin
            shreg <= data;
        end else if (shift) begin
            shreg <= {1'b0, shreg[7:1]};
        end
    end
endmodule

module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       serial,
    output logic       dv,
    output logic [7:0] data
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_MID  = CW'((CLKS_PER_BIT - 1) / 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_meta;
    logic          rx_sync;
    logic          shift;

    assign shift = enable && (state == S_DATA) && (clk_cnt == BIT_LAST);
    assign data  = shreg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            dv      <= 1'b0;
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= serial;
            rx_sync <= rx_meta;
            dv      <= 1'b0;
            if (!enable) begin
                state   <= S_IDLE;
                clk_cnt <= '0;
                bit_idx <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!rx_sync) begin
                            clk_cnt <= '0;
                            state   <= S_START;
                        end
                    end
                    S_START: begin
                        // re-check at mid start bit to reject glitches
                        if (clk_cnt == BIT_MID) begin
                            clk_cnt <= '0;
                            bit_idx <= '0;
                            state   <= rx_sync ? S_IDLE : S_DATA;
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (clk_cnt == BIT_LAST) begin
                            clk_cnt <= '0;
                            if (bit_idx == 3'd7) begin
                                state <= S_STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (clk_cnt == BIT_LAST) begin
                            clk_cnt <= '0;
                            dv      <= rx_sync;
                            state   <= S_IDLE;
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (shift) begin
            shreg <= {rx_sync, shreg[7:1]};
        end
    end
endmodule

module uart_handshake_retry #(
    parameter int         CLKS_PER_BIT = 5208,
    parameter logic [7:0] SYNC_BYTE    = 8'hFF,
    parameter logic [7:0] ACK_BYTE     = 8'hFF,
    parameter int         TIMEOUT_CLKS = 600000,
    parameter int         MAX_RETRIES  = 3,
    parameter int         GAP_CLKS     = 1000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_Rx_Serial,
    input  logic       t0,
    input  logic       clear_fail,
    output logic       o_Tx_Serial,
    output logic       busy,
    output logic       handshake_done,
    output logic       handshake_successful,
    output logic       handshake_fail,
    output logic [3:0] handshake_code,
    output logic [3:0] retry_count
);
    localparam int CNT_MAX = (TIMEOUT_CLKS > GAP_CLKS) ? TIMEOUT_CLKS : GAP_CLKS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CLKS - 1);
    localparam logic [CW-1:0] GAP_LOAD     = CW'(GAP_CLKS - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND      = 3'd1;
    localparam logic [2:0] ST_WAIT_TX   = 3'd2;
    localparam logic [2:0] ST_WAIT_RX   = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;
    localparam logic [2:0] ST_DONE_OK   = 3'd5;
    localparam logic [2:0] ST_DONE_FAIL = 3'd6;

    localparam logic [3:0] CODE_TIMEOUT  = 4'hD;
    localparam logic [3:0] CODE_MISMATCH = 4'hF;
    localparam logic [3:0] CODE_OK       = 4'hE;
    localparam logic [3:0] CODE_BUSY     = 4'h1;
    localparam logic [3:0] CODE_IDLE     = 4'h0;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          uart_en;
    logic          cause_mismatch;
    logic          tx_start;
    logic          tx_done;
    logic          rx_dv;
    logic [7:0]    rx_data;
    logic          ack_ok;
    logic          attempt_failed;
    logic          fail_mismatch;

    assign tx_start = (state == ST_SEND);
    assign ack_ok   = (state == ST_WAIT_RX) && rx_dv && (rx_data == ACK_BYTE);

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (uart_en),
        .start   (tx_start),
        .data    (SYNC_BYTE),
        .serial  (o_Tx_Serial),
        .done    (tx_done)
    );

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (uart_en),
        .serial  (i_Rx_Serial),
        .dv      (rx_dv),
        .data    (rx_data)
    );

    // A received byte takes priority over a timeout landing on the same cycle.
    always_comb begin
        attempt_failed = 1'b0;
        fail_mismatch  = 1'b0;
        if (state == ST_WAIT_RX) begin
            if (rx_dv) begin
                if (rx_data != ACK_BYTE) begin
                    attempt_failed = 1'b1;
                    fail_mismatch  = 1'b1;
                end
            end else if (cnt == '0) begin
                attempt_failed = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                <= ST_IDLE;
            cnt                  <= '0;
            uart_en              <= 1'b0;
            cause_mismatch       <= 1'b0;
            busy                 <= 1'b0;
            handshake_done       <= 1'b0;
            handshake_successful <= 1'b0;
            handshake_fail       <= 1'b0;
            retry_count          <= '0;
        end else if (clear_fail) begin
            state                <= ST_IDLE;
            cnt                  <= '0;
            uart_en              <= 1'b0;
            cause_mismatch       <= 1'b0;
            busy                 <= 1'b0;
            handshake_done       <= 1'b0;
            handshake_successful <= 1'b0;
            handshake_fail       <= 1'b0;
            retry_count          <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE_OK: begin
                    if (t0 && !handshake_fail) begin
                        state                <= ST_SEND;
                        handshake_done       <= 1'b0;
                        handshake_successful <= 1'b0;
                        retry_count          <= '0;
                        busy                 <= 1'b1;
                        uart_en              <= 1'b1;
                    end
                end
                ST_SEND: state <= ST_WAIT_TX;
                ST_WAIT_TX: begin
                    if (tx_done) begin
                        handshake_done <= 1'b1;
                        cnt            <= TIMEOUT_LOAD;
                        state          <= ST_WAIT_RX;
                    end
                end
                ST_WAIT_RX: begin
                    if (ack_ok) begin
                        state                <= ST_DONE_OK;
                        handshake_successful <= 1'b1;
                        busy                 <= 1'b0;
                        uart_en              <= 1'b0;
                    end else if (attempt_failed) begin
                        if (retry_count < RETRY_LIMIT) begin
                            retry_count    <= retry_count + 4'd1;
                            handshake_done <= 1'b0;
                            cnt            <= GAP_LOAD;
                            state          <= ST_GAP;
                        end else begin
                            state          <= ST_DONE_FAIL;
                            handshake_fail <= 1'b1;
                            cause_mismatch <= fail_mismatch;
                            busy           <= 1'b0;
                            uart_en        <= 1'b0;
                        end
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        state <= ST_SEND;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE_FAIL: state <= ST_DONE_FAIL;
                default:      state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        handshake_code = CODE_IDLE;
        if (handshake_fail) begin
            handshake_code = cause_mismatch ? CODE_MISMATCH : CODE_TIMEOUT;
        end else if (handshake_successful) begin
            handshake_code = CODE_OK;
        end else if (busy) begin
            handshake_code = CODE_BUSY;
        end
    end
endmodule

// File: tb/tb_uart_handshake_retry.sv
// Bench for uart_handshake_retry: a UART peer model answers SYNC bytes; expected end-of-handshake status is queued per t0.

module tb_uart_handshake_retry;
    localparam int CPB = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_Rx_Serial = 1'b1;
    logic       t0 = 1'b0;
    logic       clear_fail = 1'b0;
    logic       o_Tx_Serial;
    logic       busy;
    logic       handshake_done;
    logic       handshake_successful;
    logic       handshake_fail;
    logic [3:0] handshake_code;
    logic [3:0] retry_count;

    uart_handshake_retry #(
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'hFF),
        .ACK_BYTE     (8'hFF),
        .TIMEOUT_CLKS (200),
        .MAX_RETRIES  (2),
        .GAP_CLKS     (10)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .i_Rx_Serial          (i_Rx_Serial),
        .t0                   (t0),
        .clear_fail           (clear_fail),
        .o_Tx_Serial          (o_Tx_Serial),
        .busy                 (busy),
        .handshake_done       (handshake_done),
        .handshake_successful (handshake_successful),
        .handshake_fail       (handshake_fail),
        .handshake_code       (handshake_code),
        .retry_count          (retry_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Peer modes: 0 silent, 1 echo FF, 2 5A then FF, 3 always 00, 4 echo FF after a long delay
    int mode = 0;
    int tx_bytes = 0;
    int tx_base = 0;

    typedef struct {
        logic       succ;
        logic       fail;
        logic [3:0] code;
        logic [3:0] retry;
        int         syncs;
    } exp_t;
    exp_t sb_q[$];

    task automatic send_byte(input logic [7:0] b);
        i_Rx_Serial = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            i_Rx_Serial = b[i];
            repeat (CPB) @(negedge clock);
        end
        i_Rx_Serial = 1'b1;
        repeat (CPB) @(negedge clock);
    endtask

    initial begin : peer
        logic [7:0] rx_b;
        int n;
        forever begin
            @(negedge o_Tx_Serial);
            repeat (2) @(negedge clock);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clock);
                rx_b[i] = o_Tx_Serial;
            end
            repeat (CPB) @(negedge clock);
            tx_bytes++;
            n = tx_bytes - tx_base;
            case (mode)
                1: begin repeat (2*CPB) @(negedge clock); send_byte(8'hFF); end
                2: begin repeat (2*CPB) @(negedge clock); send_byte((n == 1) ? 8'h5A : 8'hFF); end
                3: begin repeat (2*CPB) @(negedge clock); send_byte(8'h00); end
                4: begin repeat (100) @(negedge clock); send_byte(8'hFF); end
                default: ;
            endcase
        end
    end

    logic prev_busy = 1'b0;
    always @(negedge clock) begin
        if (reset_n && prev_busy && !busy && sb_q.size() != 0) begin
            chk("succ",  handshake_successful, sb_q[0].succ);
            chk("fail",  handshake_fail,       sb_q[0].fail);
            chk("code",  handshake_code,       sb_q[0].code);
            chk("retry", retry_count,          sb_q[0].retry);
            chk("done",  handshake_done,       1);
            chk("syncs", tx_bytes - tx_base,   sb_q[0].syncs);
            void'(sb_q.pop_front());
        end
        prev_busy <= busy;
    end

    task automatic pulse_t0();
        @(negedge clock) t0 = 1'b1;
        @(negedge clock) t0 = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        chk("sb_drain", sb_q.size(), 0);
        sb_q.delete();
        repeat (20) @(negedge clock);
    endtask

    task automatic run_hs(input int m, input logic s, input logic f, input logic [3:0] c,
                          input logic [3:0] r, input int syncs, input int extra_t0);
        mode = m;
        tx_base = tx_bytes;
        sb_q.push_back('{s, f, c, r, syncs});
        pulse_t0();
        for (int i = 0; i < extra_t0; i++) begin
            repeat (9) @(negedge clock);
            pulse_t0();
        end
        wait_drain();
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_tx",   o_Tx_Serial, 1);
        chk("rst_code", handshake_code, 0);
        chk("rst_busy", busy, 0);
        chk("rst_retry", retry_count, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // 1: immediate echo
        run_hs(1, 1'b1, 1'b0, 4'hE, 4'd0, 1, 0);

        // 2: silent peer exhausts all attempts, then t0 is ignored
        run_hs(0, 1'b0, 1'b1, 4'hD, 4'd2, 3, 0);
        tx_base = tx_bytes;
        pulse_t0();
        repeat (100) @(negedge clock);
        chk("fail_t0_busy",  busy, 0);
        chk("fail_t0_code",  handshake_code, 4'hD);
        chk("fail_t0_syncs", tx_bytes - tx_base, 0);

        // clear_fail together with t0: t0 must not start a handshake
        @(negedge clock) begin clear_fail = 1'b1; t0 = 1'b1; end
        @(negedge clock) begin clear_fail = 1'b0; t0 = 1'b0; end
        repeat (3) @(negedge clock);
        chk("clr_code", handshake_code, 4'h0);
        chk("clr_busy", busy, 0);

        // 3: mismatch then good ack on the retry
        run_hs(2, 1'b1, 1'b0, 4'hE, 4'd1, 2, 0);

        // 4: always mismatching peer, clear, then good peer
        run_hs(3, 1'b0, 1'b1, 4'hF, 4'd2, 3, 0);
        @(negedge clock) clear_fail = 1'b1;
        @(negedge clock) clear_fail = 1'b0;
        chk("clr2_code",  handshake_code, 4'h0);
        chk("clr2_fail",  handshake_fail, 0);
        chk("clr2_retry", retry_count, 0);
        run_hs(1, 1'b1, 1'b0, 4'hE, 4'd0, 1, 0);

        // 5: t0 hammered while the attempt is in flight
        run_hs(4, 1'b1, 1'b0, 4'hE, 4'd0, 1, 12);

        // 6: async reset in the middle of the SYNC byte
        mode = 0;
        pulse_t0();
        repeat (15) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_tx",   o_Tx_Serial, 1);
        chk("arst_busy", busy, 0);
        chk("arst_done", handshake_done, 0);
        chk("arst_code", handshake_code, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (60) @(negedge clock);
        run_hs(1, 1'b1, 1'b0, 4'hE, 4'd0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
